// File: rtl/mux_sp_nch.sv
// Tagged sample stream steered into per-channel first-word-fall-through FIFOs,
// re-emitted as channel-aligned frames with a guaranteed minimum frame spacing.
module mux_sp_nch #(
    parameter int DATA_WIDTH   = 24,
    parameter int NUM_CH       = 4,
    parameter int CHIDX_WIDTH  = 4,
    parameter int CH_BASE      = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int OUT_INTERVAL = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Flush,
    input  logic [DATA_WIDTH-1:0]        Data_In,
    input  logic                         Data_In_Valid,
    input  logic [CHIDX_WIDTH-1:0]       Data_In_ChIdx,
    input  logic                         Ovf_Clr,
    output logic [NUM_CH*DATA_WIDTH-1:0] Data_Out,
    output logic                         Data_Out_Valid,
    output logic [NUM_CH-1:0]            Ch_Empty,
    output logic [NUM_CH-1:0]            Ovf_Flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(OUT_INTERVAL);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(OUT_INTERVAL - 2);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_CH];
    logic [PTR_W:0]        count_q  [NUM_CH];
    logic [PTR_W:0]        count_d  [NUM_CH];

    logic [31:0]       tag_ext;
    logic [NUM_CH-1:0] tag_hit;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] ovf_set;
    logic              pop;

    // Frame FSM and output registers
    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [NUM_CH*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_CH-1:0]        ovf_q, ovf_d;

    assign tag_ext = 32'(Data_In_ChIdx);

    // Write-side decode. A full FIFO refuses the write even if it is popped on
    // the same edge, so stored data is never overwritten.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            tag_hit[k] = Data_In_Valid && (tag_ext == 32'(CH_BASE + k));
            full[k]    = (count_q[k] == DEPTH_C);
            empty[k]   = (count_q[k] == '0);
            push[k]    = tag_hit[k] && !full[k] && !Flush;
            ovf_set[k] = tag_hit[k] &&  full[k] && !Flush;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;

        if (Flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (empty == '0) begin
                        pop     = 1'b1;
                        valid_d = 1'b1;
                        cnt_d   = HOLD_CNT;
                        state_d = ST_HOLD;
                        for (int k = 0; k < NUM_CH; k++) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_ptr_q[k]];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (Flush) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                count_d[k]  = '0;
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push[k]);
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop);
                count_d[k]  = count_q[k] + (PTR_W+1)'(push[k]) - (PTR_W+1)'(pop);
            end
        end
    end

    // Set beats clear when both happen on the same edge.
    always_comb begin
        if (Flush) begin
            ovf_d = '0;
        end else begin
            ovf_d = (ovf_q & ~{NUM_CH{Ovf_Clr}}) | ovf_set;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ovf_q    <= '0;
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            count_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is governed solely by the
    // reset counts, so stale words are never observable and the array can map to RAM.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= Data_In;
            end
        end
    end

    assign Data_Out       = data_q;
    assign Data_Out_Valid = valid_q;
    assign Ch_Empty       = empty;
    assign Ovf_Flag       = ovf_q;

endmodule

// File: tb/tb_mux_sp_nch.sv
// Scoreboard bench for mux_sp_nch: queue-based reference model predicts every frame,
// occupancy flag and overflow flag; a second small instance covers a 2-channel build.
module tb_mux_sp_nch;

    localparam int DW    = 24;
    localparam int NCH   = 4;
    localparam int CB    = 1;
    localparam int DEPTH = 16;
    localparam int OI    = 8;
    localparam int FW    = NCH * DW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Flush = 1'b0;
    logic [DW-1:0] Data_In = '0;
    logic          Data_In_Valid = 1'b0;
    logic [3:0]    Data_In_ChIdx = '0;
    logic          Ovf_Clr = 1'b0;
    logic [FW-1:0] Data_Out;
    logic          Data_Out_Valid;
    logic [NCH-1:0] Ch_Empty;
    logic [NCH-1:0] Ovf_Flag;

    logic          d2_valid = 1'b0;
    logic [3:0]    d2_tag = '0;
    logic [DW-1:0] d2_data = '0;
    logic [2*DW-1:0] d2_out;
    logic          d2_ov;
    logic [1:0]    d2_empty;
    logic [1:0]    d2_ovf;

    mux_sp_nch #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .CHIDX_WIDTH(4), .CH_BASE(CB),
        .FIFO_DEPTH(DEPTH), .OUT_INTERVAL(OI)
    ) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush), .Data_In(Data_In),
        .Data_In_Valid(Data_In_Valid), .Data_In_ChIdx(Data_In_ChIdx),
        .Ovf_Clr(Ovf_Clr), .Data_Out(Data_Out), .Data_Out_Valid(Data_Out_Valid),
        .Ch_Empty(Ch_Empty), .Ovf_Flag(Ovf_Flag)
    );

    mux_sp_nch #(
        .DATA_WIDTH(DW), .NUM_CH(2), .CHIDX_WIDTH(4), .CH_BASE(1),
        .FIFO_DEPTH(4), .OUT_INTERVAL(2)
    ) dut2 (
        .CLK(CLK), .RST(RST), .Flush(1'b0), .Data_In(d2_data),
        .Data_In_Valid(d2_valid), .Data_In_ChIdx(d2_tag),
        .Ovf_Clr(1'b0), .Data_Out(d2_out), .Data_Out_Valid(d2_ov),
        .Ch_Empty(d2_empty), .Ovf_Flag(d2_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            edge_n;
        logic [FW-1:0] data;
    } frame_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en  = 1'b0;
    bit mon2_en = 1'b0;

    // Reference model state
    logic [DW-1:0]  chq [NCH][$];
    logic [NCH-1:0] ovf_m;
    logic [FW-1:0]  dout_m;
    int             last_frame;
    frame_t         exp_q[$];
    frame_t         cur;

    logic [2*DW-1:0] exp2_q[$];
    int last2 = -1;
    int n2    = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] empty_m();
        logic [NCH-1:0] e;
        for (int k = 0; k < NCH; k++) e[k] = (chq[k].size() == 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) chq[k].delete();
        ovf_m      = '0;
        dout_m     = '0;
        last_frame = -1000;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus and advance the model by the edge it produces.
    // A frame leaves at the first edge where every channel already holds a word
    // and at least OI edges have passed since the previous frame.
    task automatic step(input bit v, input logic [3:0] tag, input logic [DW-1:0] d,
                        input bit fl, input bit clr);
        int             e;
        int             kin;
        bit             frame;
        bit             hit;
        bit             full_w;
        logic [NCH-1:0] set_m;
        logic [FW-1:0]  fd;
        frame_t         f;
        Data_In_Valid = v;
        Data_In_ChIdx = tag;
        Data_In       = d;
        Flush         = fl;
        Ovf_Clr       = clr;
        @(posedge CLK);
        #1;
        e = cyc + 1;
        if (fl) begin
            for (int k = 0; k < NCH; k++) chq[k].delete();
            ovf_m      = '0;
            last_frame = -1000;
        end else begin
            frame = (e - last_frame >= OI);
            for (int k = 0; k < NCH; k++) if (chq[k].size() == 0) frame = 1'b0;
            kin    = int'(tag) - CB;
            hit    = v && (kin >= 0) && (kin < NCH);
            full_w = 1'b0;
            if (hit) full_w = (chq[kin].size() == DEPTH);
            set_m  = '0;
            if (frame) begin
                fd = '0;
                for (int k = 0; k < NCH; k++) fd[k*DW +: DW] = chq[k].pop_front();
                f.edge_n = e;
                f.data   = fd;
                exp_q.push_back(f);
                dout_m     = fd;
                last_frame = e;
            end
            if (hit) begin
                if (full_w) set_m[kin] = 1'b1;
                else        chq[kin].push_back(d);
            end
            ovf_m = (clr ? '0 : ovf_m) | set_m;
        end
        cyc = e;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values();
        check("rst_data_out", Data_Out, '0);
        check("rst_valid", FW'(Data_Out_Valid), '0);
        check("rst_ch_empty", FW'(Ch_Empty), FW'(4'hF));
        check("rst_ovf", FW'(Ovf_Flag), '0);
    endtask

    // Main monitor: pops the scoreboard whenever a frame is due and checks status every cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                cur = exp_q.pop_front();
                check("frame_strobe", FW'(Data_Out_Valid), FW'(1));
                check("frame_data", Data_Out, cur.data);
            end else begin
                check("no_strobe", FW'(Data_Out_Valid), '0);
            end
            check("data_out_hold", Data_Out, dout_m);
            check("ch_empty", FW'(Ch_Empty), FW'(empty_m()));
            check("ovf_flag", FW'(Ovf_Flag), FW'(ovf_m));
        end
    end

    // Two-channel instance monitor: I/Q pairs in order, one frame every 2 cycles.
    always @(negedge CLK) begin
        if (mon2_en) begin
            if (d2_ov) begin
                if (exp2_q.size() == 0) begin
                    check("sweep_unexpected_strobe", FW'(d2_ov), '0);
                end else begin
                    check("sweep_data", FW'(d2_out), FW'(exp2_q.pop_front()));
                end
                if (last2 >= 0) check("sweep_spacing", FW'(cyc - last2), FW'(2));
                last2 = cyc;
                n2++;
            end
            check("sweep_ovf", FW'(d2_ovf), '0);
        end
    end

    initial begin
        logic [DW-1:0] iv;
        logic [DW-1:0] qv;
        logic [3:0]    tags [8];
        model_reset();
        tags = '{4'd0, 4'd1, 4'd5, 4'd2, 4'd0, 4'd3, 4'd5, 4'd4};

        repeat (3) @(posedge CLK);
        #1;
        check_reset_values();
        @(negedge CLK);
        #1;
        RST     = 1'b0;
        mon_en  = 1'b1;
        mon2_en = 1'b1;

        // Single frame
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), DW'((i + 1) * 17), 1'b0, 1'b0);
        repeat (12) idle();

        // Pacing: three samples per channel, then stall
        for (int ch = 0; ch < NCH; ch++)
            for (int j = 0; j < 3; j++) step(1'b1, 4'(ch + 1), DW'($urandom), 1'b0, 1'b0);
        repeat (40) idle();

        // Overflow on tag 2, set wins over a simultaneous clear
        for (int j = 0; j < 17; j++) step(1'b1, 4'd2, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd2, DW'($urandom), 1'b0, 1'b1);
        repeat (3) idle();
        step(1'b1, 4'd1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd3, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd4, DW'($urandom), 1'b0, 1'b0);
        repeat (3) idle();
        step(1'b0, 4'd0, '0, 1'b0, 1'b1);
        // Flush during HOLD together with a write
        step(1'b1, 4'd3, 24'hABCDEF, 1'b1, 1'b0);
        repeat (12) idle();

        // Illegal tags interleaved with legal ones
        for (int i = 0; i < 8; i++) step(1'b1, tags[i], DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 80; i++)
            step(1'($urandom % 2), 4'($urandom_range(0, 15)), DW'($urandom), 1'b0, 1'b0);
        repeat (40) idle();

        // Full-rate stress with occasional clear and flush
        for (int i = 0; i < 150; i++)
            step(1'b1, 4'($urandom_range(1, 4)), DW'($urandom),
                 ($urandom % 25) == 0, ($urandom % 10) == 0);
        repeat (40) idle();

        // Asynchronous reset in the middle of HOLD with data still buffered
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd2, DW'($urandom), 1'b0, 1'b0);
        repeat (2) idle();
        #2;
        mon_en = 1'b0;
        RST    = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        RST    = 1'b0;
        mon_en = 1'b1;
        repeat (4) idle();

        // Two-channel build with back-to-back I/Q writes
        for (int n = 0; n < 40; n++) begin
            iv = DW'($urandom);
            qv = DW'($urandom);
            d2_valid = 1'b1; d2_tag = 4'd1; d2_data = iv;
            idle();
            d2_tag = 4'd2; d2_data = qv;
            idle();
            exp2_q.push_back({qv, iv});
        end
        d2_valid = 1'b0;
        repeat (6) idle();

        check("sweep_frame_count", FW'(n2), FW'(40));
        check("sweep_empty", FW'(d2_empty), FW'(2'b11));
        check("drain", FW'(exp_q.size()), '0);
        mon_en  = 1'b0;
        mon2_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sp_nch.md
# mux_sp_nch

Parametrised serial-to-parallel demultiplexer for the DDC output path. It accepts a time-multiplexed sample stream tagged with a channel index and steers each sample into a per-channel FIFO. When every channel holds data, it emits one aligned frame carrying one sample per channel, with a guaranteed minimum spacing between frames. Unlike the two-channel I/Q splitter, it runs entirely in the CLK domain, scales to NUM_CH channels, and reports overflow.

## Interface
- DATA_WIDTH, 24, sample width (signed two's complement)
- NUM_CH, 4, number of channels (1..8)
- CHIDX_WIDTH, 4, width of the channel-index tag
- CH_BASE, 1, tag value of channel 0; channel k has tag CH_BASE+k
- FIFO_DEPTH, 16, words per channel FIFO (power of 2, ≥2)
- OUT_INTERVAL, 8, minimum CLK cycles between frame strobes (≥2)
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous clear of all FIFOs, the FSM and the overflow flags
- Data_In  in  DATA_WIDTH  input sample
- Data_In_Valid  in  1  single-cycle write strobe, sampled on the CLK edge
- Data_In_ChIdx  in  CHIDX_WIDTH  channel tag of Data_In
- Ovf_Clr  in  1  clears all Ovf_Flag bits
- Data_Out  out  NUM_CH*DATA_WIDTH  frame; channel k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- Data_Out_Valid  out  1  one-cycle frame strobe
- Ch_Empty  out  NUM_CH  per-channel FIFO-empty status
- Ovf_Flag  out  NUM_CH  sticky per-channel overflow flag

## Operation
- **Write path.** When Data_In_Valid=1 and Data_In_ChIdx−CH_BASE falls in 0..NUM_CH−1, Data_In is pushed into that channel's FIFO.
  - A tag outside that range is silently ignored and no flag is raised.
- **Full FIFO.** A write to a full FIFO is dropped and sets Ovf_Flag[k].
  - The write is dropped even if the same FIFO is popped on the same edge.
  - Stored data is never overwritten.
- **FIFO structure.** Each FIFO is first-word fall-through: the head word is visible combinationally.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - Occupancy uses a separate count register, 0..FIFO_DEPTH.
- **FSM states.** IDLE and HOLD, plus a down-counter cnt of width clog2(OUT_INTERVAL).
- **IDLE.** Data_Out_Valid <= 0 unless the frame condition below holds.
  - Frame condition: all Ch_Empty bits are 0.
  - On the frame condition, all FIFOs pop simultaneously, the head words load into Data_Out, Data_Out_Valid <= 1, cnt <= OUT_INTERVAL−2, and the FSM goes to HOLD.
- **HOLD.** Data_Out_Valid <= 0.
  - If cnt==0, go to IDLE; otherwise cnt <= cnt−1.
- **Data_Out hold.** Data_Out keeps its value between frames.
- **Flush.** Clears pointers and counts, state goes to IDLE, cnt=0, Data_Out_Valid=0, Ovf_Flag=0, Data_Out is kept.
  - Flush takes priority over a simultaneous write and over the frame condition.
- **Ovf_Clr.** Clears Ovf_Flag. If an overflow occurs on the same edge, set wins.
- **Arithmetic.** No arithmetic is applied to the data; samples pass bit-exact.

## Timing
- **Reset values.** Data_Out=0, Data_Out_Valid=0, Ch_Empty=all 1s, Ovf_Flag=0, state=IDLE, cnt=0, all FIFOs empty.
  - Reset asserted mid-frame or mid-HOLD aborts immediately.
  - Buffered samples are lost on reset.
- **Write to Ch_Empty.** A write strobed at edge t updates Ch_Empty after edge t.
- **Frame latency.**
  - The FSM sees the last-filled channel at edge t+1.
  - Data_Out_Valid is high during the cycle following edge t+1, i.e. 2 cycles after the completing write.
- **Frame spacing.** Frame strobes are spaced by ≥ OUT_INTERVAL cycles, and exactly OUT_INTERVAL when data is continuously available.
- **Concurrent access.** A push and a pop on the same FIFO in one cycle are both honoured when the FIFO is not full; occupancy is then unchanged.
- **Throughput.** Input rate may reach one sample per cycle. Sustained input faster than NUM_CH samples per OUT_INTERVAL cycles causes overflow.

## Test plan
- **Reset and single frame.**
  - Stimulus: release RST, then write tags 1,2,3,4 with data 0x000011, 0x000022, 0x000033, 0x000044 on consecutive cycles.
  - Response: exactly one Data_Out_Valid pulse, 2 cycles after the tag-4 write, with Data_Out = 0x000044_000033_000022_000011, and Ch_Empty=4'b1111 afterwards.
- **Pacing.**
  - Stimulus: preload 3 samples per channel, then stall input.
  - Response: 3 strobes spaced exactly 8 cycles apart, data in FIFO order, then no further strobes.
- **Overflow.**
  - Stimulus: write 17 samples to tag 2 only.
  - Response: Ovf_Flag=4'b0010 and no frame emitted.
  - Then: fill the other channels. Channel 1 in the first frame holds the 1st tag-2 sample, never the 17th.
  - Then: Ovf_Clr clears the flag.
- **Illegal tags.**
  - Stimulus: writes with tag 0 and tag 5 interleaved among valid tags.
  - Response: illegal writes are ignored, frames contain only valid-tag data, and Ovf_Flag stays 0.
- **Flush and reset mid-HOLD.**
  - Stimulus: assert Flush during HOLD together with a write.
  - Response: all Ch_Empty bits are 1, no strobe follows, the write is discarded, and Data_Out is unchanged.
  - Then: assert RST asynchronously mid-cycle. All outputs go to their reset values immediately.
- **Parameter sweep.**
  - Stimulus: NUM_CH=2, CH_BASE=1, FIFO_DEPTH=4, OUT_INTERVAL=2, with back-to-back I/Q writes.
  - Response: one frame every 2 cycles and no overflow.
